// File: rtl/fetch_queue_pkg.sv
// Shared pipeline constants and stage codes used by fetch, decode and EX.
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INS  = 32'h0000_0013;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    typedef enum logic [1:0] {
        STAGE_IDLE  = 2'd0,
        STAGE_BUSY  = 2'd1,
        STAGE_STALL = 2'd2,
        STAGE_FLUSH = 2'd3
    } stage_e;

    function automatic logic is_nop(input logic [31:0] ins);
        return ins == NOP_INS;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: I-cache push side, decode pop side, queue status.
interface fetch_queue_if #(
    parameter int DEPTH     = 4,
    parameter int PC_WIDTH  = 32,
    parameter int INS_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 FLUSH;
    logic                 INS_CACHE_READY;
    logic [INS_WIDTH-1:0] INS_IN;
    logic [PC_WIDTH-1:0]  PC_IN;
    logic                 STALL_ENABLE;
    logic                 DATA_CACHE_READY;
    logic                 EXSTAGE_STALLED;
    logic                 FETCH_READY;
    logic [INS_WIDTH-1:0] INSTRUCTION;
    logic [PC_WIDTH-1:0]  PC_OUT;
    logic                 INS_VALID;
    logic [CW-1:0]        COUNT;

    modport slave (
        input  FLUSH, INS_CACHE_READY, INS_IN, PC_IN,
               STALL_ENABLE, DATA_CACHE_READY, EXSTAGE_STALLED,
        output FETCH_READY, INSTRUCTION, PC_OUT, INS_VALID, COUNT
    );

    modport master (
        output FLUSH, INS_CACHE_READY, INS_IN, PC_IN,
               STALL_ENABLE, DATA_CACHE_READY, EXSTAGE_STALLED,
        input  FETCH_READY, INSTRUCTION, PC_OUT, INS_VALID, COUNT
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one asynchronous read port.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order {PC, instruction} buffer between I-cache and decode with registered head view.
// Optional FETCH_QUEUE_BYPASS_EN: empty-queue push drives decode combinationally.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PC_WIDTH  = 32,
    parameter int INS_WIDTH = 32
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_queue_if.slave  q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = PC_WIDTH + INS_WIDTH;

    logic [PW-1:0]        wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]        count_r, count_next, remain;
    logic [INS_WIDTH-1:0] ins_r;
    logic [PC_WIDTH-1:0]  pc_r;
    logic                 vld_r;
    logic                 fetch_ready, push_req, bypass, ins_valid, pop, pop_q, write;
    logic                 head_from_in;
    logic [EW-1:0]        rdata;

    assign fetch_ready = (count_r != CW'(DEPTH));
    assign push_req    = q.INS_CACHE_READY & fetch_ready & ~q.FLUSH;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = push_req & (count_r == '0) & ~RST;
`else
    assign bypass = 1'b0;
`endif

    assign ins_valid = vld_r | bypass;
    assign pop       = ins_valid & q.STALL_ENABLE & q.DATA_CACHE_READY
                       & ~q.EXSTAGE_STALLED & ~q.FLUSH;
    // A bypassed entry that decode accepts immediately never enters storage.
    assign pop_q     = pop & vld_r;
    assign write     = push_req & ~(bypass & pop);

    assign rd_next      = rd_ptr + PW'(pop_q);
    assign remain       = count_r - CW'(pop_q);
    assign count_next   = remain + CW'(write);
    assign head_from_in = write & (remain == '0);

    fetch_queue_mem #(.DEPTH(DEPTH), .WIDTH(EW)) u_mem (
        .clk   (CLK),
        .we    (write),
        .waddr (wr_ptr),
        .wdata ({q.PC_IN, q.INS_IN}),
        .raddr (rd_next),
        .rdata (rdata)
    );

    // Head-view register stage: reflects the entry at the head after this edge's push/pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            vld_r   <= 1'b0;
            ins_r   <= INS_WIDTH'(NOP_INS);
            pc_r    <= PC_WIDTH'(PC_RESET);
        end else if (q.FLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            vld_r   <= 1'b0;
            ins_r   <= INS_WIDTH'(NOP_INS);
        end else begin
            wr_ptr  <= wr_ptr + PW'(write);
            rd_ptr  <= rd_next;
            count_r <= count_next;
            vld_r   <= (count_next != '0);
            if (count_next == '0) begin
                ins_r <= INS_WIDTH'(NOP_INS);
            end else if (head_from_in) begin
                ins_r <= q.INS_IN;
                pc_r  <= q.PC_IN;
            end else begin
                ins_r <= rdata[INS_WIDTH-1:0];
                pc_r  <= rdata[EW-1:INS_WIDTH];
            end
        end
    end

    assign q.FETCH_READY = fetch_ready;
    assign q.INS_VALID   = ins_valid;
    assign q.COUNT       = count_r;
    assign q.INSTRUCTION = bypass ? q.INS_IN : ins_r;
    assign q.PC_OUT      = bypass ? q.PC_IN  : pc_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences, random traffic vs a queue model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fetch_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(32), .INS_WIDTH(32)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .INS_WIDTH(32)) dut (
        .CLK (clk),
        .RST (rst),
        .q   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of pending {pc, ins} entries.
    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];
    logic [31:0] last_pc;
    bit          mdl_ok = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit full, push, byp, valid, pop;
        if (rst) begin
            mq_pc.delete();
            mq_ins.delete();
            last_pc = 32'h0;
            mdl_ok  = 1;
        end else if (bus.FLUSH) begin
            mq_pc.delete();
            mq_ins.delete();
        end else begin
            full  = (mq_pc.size() == DEPTH);
            push  = bus.INS_CACHE_READY && !full;
            byp   = BYP && push && (mq_pc.size() == 0);
            valid = (mq_pc.size() > 0) || byp;
            pop   = valid && bus.STALL_ENABLE && bus.DATA_CACHE_READY && !bus.EXSTAGE_STALLED;
            if (push) begin
                mq_pc.push_back(bus.PC_IN);
                mq_ins.push_back(bus.INS_IN);
            end
            if (pop) begin
                void'(mq_pc.pop_front());
                void'(mq_ins.pop_front());
            end
        end
        if (mq_pc.size() > 0) last_pc = mq_pc[0];
    endtask

    task automatic compare_model();
        bit          byp;
        logic [31:0] e_ins, e_pc;
        if (!mdl_ok) return;
        byp   = BYP && !rst && !bus.FLUSH && bus.INS_CACHE_READY && (mq_pc.size() == 0);
        e_ins = (mq_pc.size() > 0) ? mq_ins[0] : (byp ? bus.INS_IN : NOP);
        e_pc  = (mq_pc.size() > 0) ? mq_pc[0]  : (byp ? bus.PC_IN  : last_pc);
        check("model_count", bus.COUNT, mq_pc.size());
        check("model_fetch_ready", bus.FETCH_READY, mq_pc.size() != DEPTH);
        check("model_valid", bus.INS_VALID, (mq_pc.size() > 0) || byp);
        check("model_ins", bus.INSTRUCTION, e_ins);
        check("model_pc", bus.PC_OUT, e_pc);
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input logic r, input logic f, input logic icr, input logic [31:0] pc,
                         input logic se, input logic dcr, input logic exs);
        rst                  = r;
        bus.FLUSH            = f;
        bus.INS_CACHE_READY  = icr;
        bus.PC_IN            = pc;
        bus.INS_IN           = pc ^ KEY;
        bus.STALL_ENABLE     = se;
        bus.DATA_CACHE_READY = dcr;
        bus.EXSTAGE_STALLED  = exs;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 1, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 1, 1, 1);
    endtask

    typedef struct {
        logic        icr;
        logic [31:0] pc;
        logic        exs;
        logic [2:0]  cnt;
        logic        fr;
        logic        vld;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 0, 0, 0, 1, 1, 1);
        @(negedge clk);

        // Reset held two cycles while the I-cache keeps pushing.
        drive(1, 0, 1, 32'h44, 1, 1, 0);
        cyc();
        cyc();
        check("rst_count", bus.COUNT, 0);
        check("rst_valid", bus.INS_VALID, 0);
        check("rst_ins", bus.INSTRUCTION, NOP);
        check("rst_pc", bus.PC_OUT, 0);
        check("rst_fetch_ready", bus.FETCH_READY, 1);
        drive(0, 0, 0, 0, 1, 1, 1);
        cyc();

        // Fill while EX is stalled, overflow push ignored, then drain in order.
        tbl[0] = '{1, 32'h00, 1, 1, 1, 1, 32'h00};
        tbl[1] = '{1, 32'h04, 1, 2, 1, 1, 32'h00};
        tbl[2] = '{1, 32'h08, 1, 3, 1, 1, 32'h00};
        tbl[3] = '{1, 32'h0C, 1, 4, 0, 1, 32'h00};
        tbl[4] = '{1, 32'h10, 1, 4, 0, 1, 32'h00};
        tbl[5] = '{0, 32'h00, 0, 3, 1, 1, 32'h04};
        tbl[6] = '{0, 32'h00, 0, 2, 1, 1, 32'h08};
        tbl[7] = '{0, 32'h00, 0, 1, 1, 1, 32'h0C};
        tbl[8] = '{0, 32'h00, 0, 0, 1, 0, 32'h0C};
        tbl[9] = '{0, 32'h00, 0, 0, 1, 0, 32'h0C};
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, tbl[i].icr, tbl[i].pc, 1, 1, tbl[i].exs);
            cyc();
            check($sformatf("fill_count[%0d]", i), bus.COUNT, tbl[i].cnt);
            check($sformatf("fill_ready[%0d]", i), bus.FETCH_READY, tbl[i].fr);
            check($sformatf("fill_valid[%0d]", i), bus.INS_VALID, tbl[i].vld);
            check($sformatf("fill_pc[%0d]", i), bus.PC_OUT, tbl[i].epc);
            check($sformatf("fill_ins[%0d]", i), bus.INSTRUCTION,
                  tbl[i].vld ? (tbl[i].epc ^ KEY) : NOP);
        end

        // Streaming push+pop: occupancy stays at one while pointers wrap.
        do_reset();
        drive(0, 0, 1, 32'h200, 1, 1, 1);
        cyc();
        for (int k = 1; k <= 20; k++) begin
            drive(0, 0, 1, 32'h200 + 32'(4 * k), 1, 1, 0);
            cyc();
            check($sformatf("stream_count[%0d]", k), bus.COUNT, 1);
            check($sformatf("stream_pc[%0d]", k), bus.PC_OUT, 32'h200 + 32'(4 * k));
        end

        // Flush with a simultaneous push and pop: both dropped.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 32'h30 + 32'(4 * k), 1, 1, 1);
            cyc();
        end
        check("flush_pre_count", bus.COUNT, 3);
        drive(0, 1, 1, 32'h40, 1, 1, 0);
        cyc();
        check("flush_count", bus.COUNT, 0);
        check("flush_valid", bus.INS_VALID, 0);
        check("flush_ins", bus.INSTRUCTION, NOP);
        drive(0, 0, 1, 32'h80, 1, 1, 1);
        cyc();
        check("flush_next_pc", bus.PC_OUT, 32'h80);
        check("flush_next_count", bus.COUNT, 1);
        drive(0, 0, 0, 0, 1, 1, 0);
        cyc();
        check("flush_drain_count", bus.COUNT, 0);

        // Each stall source alone holds the head; only full acceptance pops.
        do_reset();
        drive(0, 0, 1, 32'h20, 1, 1, 1);
        cyc();
        drive(0, 0, 0, 0, 1, 0, 0);
        cyc();
        check("stall_dcache_count", bus.COUNT, 1);
        check("stall_dcache_pc", bus.PC_OUT, 32'h20);
        drive(0, 0, 0, 0, 0, 1, 0);
        cyc();
        check("stall_hazard_count", bus.COUNT, 1);
        check("stall_hazard_pc", bus.PC_OUT, 32'h20);
        drive(0, 0, 0, 0, 1, 1, 1);
        cyc();
        check("stall_ex_count", bus.COUNT, 1);
        drive(0, 0, 0, 0, 1, 1, 0);
        cyc();
        check("stall_release_count", bus.COUNT, 0);
        check("stall_release_valid", bus.INS_VALID, 0);

        // Empty-queue push with decode accepting.
        do_reset();
        drive(0, 0, 1, 32'h100, 1, 1, 0);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("bypass_same_valid", bus.INS_VALID, 1);
        check("bypass_same_pc", bus.PC_OUT, 32'h100);
        cyc();
        check("bypass_count", bus.COUNT, 0);
`else
        check("nobypass_same_valid", bus.INS_VALID, 0);
        cyc();
        check("nobypass_next_valid", bus.INS_VALID, 1);
        check("nobypass_next_pc", bus.PC_OUT, 32'h100);
        check("nobypass_count", bus.COUNT, 1);
`endif

        // Random traffic against the model.
        begin
            logic [31:0] pc = 32'h1000;
            for (int n = 0; n < 800; n++) begin
                drive($urandom_range(0, 99) < 1,
                      $urandom_range(0, 99) < 3,
                      $urandom_range(0, 99) < 60,
                      pc,
                      $urandom_range(0, 99) < 80,
                      $urandom_range(0, 99) < 80,
                      $urandom_range(0, 99) < 25);
                bus.INS_IN = $urandom;
                pc = pc + 32'd4;
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
